// File: rtl/riscv_ras_pkg.sv
// Shared types and helpers for the return-address stack: operation
// encoding, the two control-transfer opcodes and the link-register test.
package riscv_ras_pkg;

  typedef enum logic [1:0] {
    RAS_NONE,
    RAS_PUSH,
    RAS_POP,
    RAS_POPPUSH
  } ras_op_e;

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  // x1 (ra) and x5 (t0) are the link registers by ABI hint convention
  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

endpackage

// File: rtl/riscv_ras_if.sv
// Bundle between the next-PC logic (master) and the return-address stack
// (slave): instruction stream in, return prediction and status out.
interface riscv_ras_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            instr_valid;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic            flush;
  logic            pred_valid;
  logic [XLEN-1:0] pred_target;
  logic [CW-1:0]   count;
  logic            lost;

  modport master (
    output instr_valid, instr, pc, flush,
    input  pred_valid, pred_target, count, lost
  );

  modport slave (
    input  instr_valid, instr, pc, flush,
    output pred_valid, pred_target, count, lost
  );
endinterface

// File: rtl/riscv_ras_decode.sv
// Combinational classifier: maps an RV32 instruction word to the stack
// operation implied by the link-register hints in rd/rs1.
module riscv_ras_decode
  import riscv_ras_pkg::*;
(
  input  logic [31:0] instr,
  output ras_op_e     op
);

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [2:0] funct3;
  logic       rd_link;
  logic       rs1_link;
  logic       unused_hi;

  assign opcode    = instr[6:0];
  assign rd        = instr[11:7];
  assign funct3    = instr[14:12];
  assign rs1       = instr[19:15];
  assign rd_link   = is_link(rd);
  assign rs1_link  = is_link(rs1);
  // Immediate bits play no part in classification
  assign unused_hi = ^instr[31:20];

  // Classify JAL/JALR by which of rd/rs1 are link registers
  always_comb begin
    op = RAS_NONE;
    if (opcode == OP_JAL) begin
      if (rd_link) op = RAS_PUSH;
    end else if (opcode == OP_JALR && funct3 == 3'b000) begin
      case ({rd_link, rs1_link})
        2'b10:   op = RAS_PUSH;
        2'b01:   op = RAS_POP;
        // Same link register on both sides is a plain call (e.g. jalr ra, ra)
        2'b11:   op = (rd == rs1) ? RAS_PUSH : RAS_POPPUSH;
        default: op = RAS_NONE;
      endcase
    end
  end

endmodule

// File: rtl/riscv_ras.sv
// Return-address stack: circular buffer of return addresses with a
// wrapping top pointer, live-entry count and sticky overflow flag. Returns
// are predicted combinationally from the current top entry; updates land
// on the next rising edge.
module riscv_ras
  import riscv_ras_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input logic         clk,
  input logic         rst,
  riscv_ras_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] stack [DEPTH];
  logic [PW-1:0]   tos;
  logic [CW-1:0]   count_q;
  logic            lost_q;

  ras_op_e         op;
  logic [XLEN-1:0] link_addr;
  logic            empty;
  logic            full;
  logic            is_ret;
  logic            do_push;
  logic            do_pop;
  logic            do_replace;
  logic [PW-1:0]   tos_inc;
  logic            pred_valid_c;
  logic [XLEN-1:0] pred_target_c;

  riscv_ras_decode u_decode (
    .instr (bus.instr),
    .op    (op)
  );

  // Return address wraps modulo 2^XLEN
  assign link_addr = bus.pc + XLEN'(4);
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign is_ret    = (op == RAS_POP) || (op == RAS_POPPUSH);
  assign tos_inc   = tos + PW'(1);

  // POPPUSH on an empty stack has nothing to replace, so it degrades to a push
  assign do_push    = bus.instr_valid &&
                      ((op == RAS_PUSH) || (op == RAS_POPPUSH && empty));
  assign do_pop     = bus.instr_valid && (op == RAS_POP) && !empty;
  assign do_replace = bus.instr_valid && (op == RAS_POPPUSH) && !empty;

  // Same-cycle return prediction from the current top of stack
  always_comb begin
    pred_valid_c  = 1'b0;
    pred_target_c = '0;
    if (bus.instr_valid && is_ret) begin
      pred_target_c = stack[tos];
      pred_valid_c  = !empty;
    end
  end

  // Stack, pointer, count and overflow flag; flush beats any operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
      tos     <= '0;
      count_q <= '0;
      lost_q  <= 1'b0;
    end else if (bus.flush) begin
      tos     <= '0;
      count_q <= '0;
      lost_q  <= 1'b0;
    end else if (do_push) begin
      tos            <= tos_inc;
      stack[tos_inc] <= link_addr;
      // A full stack overwrites its oldest entry, which sits at tos+1
      if (full) lost_q  <= 1'b1;
      else      count_q <= count_q + CW'(1);
    end else if (do_pop) begin
      tos     <= tos - PW'(1);
      count_q <= count_q - CW'(1);
    end else if (do_replace) begin
      stack[tos] <= link_addr;
    end
  end

  assign bus.pred_valid  = pred_valid_c;
  assign bus.pred_target = pred_target_c;
  assign bus.count       = count_q;
  assign bus.lost        = lost_q;

endmodule

// File: tb/tb_riscv_ras.sv
// Directed bench for riscv_ras: a 32-bit and a 16-bit instance share clock
// and reset; expected values are hand-computed constants.
module tb_riscv_ras;

  localparam logic [31:0] JAL_RA   = 32'h008000ef; // jal ra, 8
  localparam logic [31:0] RET      = 32'h00008067; // jalr x0, ra, 0
  localparam logic [31:0] JALR_X3  = 32'h004180e7; // jalr ra, x3, 4
  localparam logic [31:0] JALR_RA  = 32'h000080e7; // jalr ra, ra, 0
  localparam logic [31:0] JALR_T0  = 32'h000082e7; // jalr t0, ra, 0

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  riscv_ras_if #(.XLEN(32), .DEPTH(8)) bus32 ();
  riscv_ras_if #(.XLEN(16), .DEPTH(8)) bus16 ();

  riscv_ras #(.XLEN(32), .DEPTH(8)) u32 (.clk(clk), .rst(rst), .bus(bus32));
  riscv_ras #(.XLEN(16), .DEPTH(8)) u16 (.clk(clk), .rst(rst), .bus(bus16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present an instruction to the 32-bit instance in the low clock phase
  task automatic drv32(input logic [31:0] pc, input logic [31:0] ins, input logic fl = 1'b0);
    @(negedge clk);
    bus32.instr_valid = 1'b1;
    bus32.pc          = pc;
    bus32.instr       = ins;
    bus32.flush       = fl;
    #1;
  endtask

  task automatic drv16(input logic [15:0] pc, input logic [31:0] ins);
    @(negedge clk);
    bus16.instr_valid = 1'b1;
    bus16.pc          = pc;
    bus16.instr       = ins;
    #1;
  endtask

  // Let the rising edge take the presented instructions, then go idle
  task automatic commit();
    @(posedge clk);
    #1;
    bus32.instr_valid = 1'b0;
    bus32.flush       = 1'b0;
    bus16.instr_valid = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus32.instr_valid = 1'b1; bus32.instr = RET; bus32.pc = '0; bus32.flush = 1'b0;
    bus16.instr_valid = 1'b0; bus16.instr = '0;  bus16.pc = '0; bus16.flush = 1'b0;
    #12;
    chk("reset_count", bus32.count, 0);
    chk("reset_lost", bus32.lost, 0);
    chk("reset_pv", bus32.pred_valid, 0);
    chk("reset_pt", bus32.pred_target, 0);
    @(negedge clk);
    rst = 1'b0;
    bus32.instr_valid = 1'b0;

    // jal ra then ret
    drv32(32'h100, JAL_RA); commit();
    chk("t1_count_push", bus32.count, 1);
    drv32(32'h0, RET);
    chk("t1_pv", bus32.pred_valid, 1);
    chk("t1_pt", bus32.pred_target, 32'h104);
    commit();
    chk("t1_count_pop", bus32.count, 0);

    // jalr variants that push
    drv32(32'h0, JALR_X3); commit();
    drv32(32'hC, JALR_RA); commit();
    chk("t2_count", bus32.count, 2);
    drv32(32'h0, RET);
    chk("t2_pt0", bus32.pred_target, 32'h10);
    commit();
    drv32(32'h0, RET);
    chk("t2_pt1", bus32.pred_target, 32'h4);
    commit();
    chk("t2_count_end", bus32.count, 0);

    // overflow by one, drain, underflow
    for (int i = 0; i < 9; i++) begin
      drv32(32'(i * 16), JAL_RA); commit();
    end
    chk("t3_count_full", bus32.count, 8);
    chk("t3_lost", bus32.lost, 1);
    for (int i = 0; i < 8; i++) begin
      drv32(32'h0, RET);
      chk("t3_pv", bus32.pred_valid, 1);
      chk("t3_pt", bus32.pred_target, 64'(32'h84 - 32'(i * 16)));
      commit();
    end
    chk("t3_count_drained", bus32.count, 0);
    chk("t3_lost_sticky", bus32.lost, 1);
    drv32(32'h0, RET);
    chk("t3_underflow_pv", bus32.pred_valid, 0);
    commit();
    chk("t3_underflow_count", bus32.count, 0);

    // idle cycle with a call on the bus but instr_valid low
    @(negedge clk);
    bus32.instr = JAL_RA; bus32.pc = 32'h300;
    commit();
    chk("idle_count", bus32.count, 0);

    // pop+push (jalr t0, ra)
    drv32(32'h100, JAL_RA); commit();
    drv32(32'h200, JALR_T0);
    chk("t4_pv", bus32.pred_valid, 1);
    chk("t4_pt", bus32.pred_target, 32'h104);
    commit();
    chk("t4_count", bus32.count, 1);
    drv32(32'h0, RET);
    chk("t4_ret_pt", bus32.pred_target, 32'h204);
    commit();
    drv32(32'h200, JALR_T0);
    chk("t4_empty_pv", bus32.pred_valid, 0);
    commit();
    chk("t4_empty_count", bus32.count, 1);
    drv32(32'h0, RET);
    chk("t4_empty_ret_pt", bus32.pred_target, 32'h204);
    commit();

    // flush wins over a simultaneous push; lost is still set from overflow
    drv32(32'h0, JAL_RA); commit();
    drv32(32'h4, JAL_RA); commit();
    drv32(32'h8, JAL_RA); commit();
    chk("t5_count_pre", bus32.count, 3);
    drv32(32'h20, JAL_RA, 1'b1);
    commit();
    chk("t5_count", bus32.count, 0);
    chk("t5_lost", bus32.lost, 0);
    drv32(32'h0, RET);
    chk("t5_ret_pv", bus32.pred_valid, 0);
    commit();

    // 16-bit wrap of the return address, then asynchronous reset
    drv16(16'hFFFC, JAL_RA); commit();
    chk("t6_count16", bus16.count, 1);
    drv16(16'h0, RET);
    chk("t6_pv16", bus16.pred_valid, 1);
    chk("t6_wrap_pt", bus16.pred_target, 16'h0000);
    commit();
    drv32(32'h40, JAL_RA); commit();
    drv16(16'h10, JAL_RA); commit();
    drv16(16'h0, RET);
    chk("t6_pt16_pre", bus16.pred_target, 16'h14);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_pv16", bus16.pred_valid, 0);
    chk("t6_rst_pt16", bus16.pred_target, 0);
    chk("t6_rst_count16", bus16.count, 0);
    chk("t6_rst_count32", bus32.count, 0);
    @(negedge clk);
    rst = 1'b0;
    bus16.instr_valid = 1'b0;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_ras.md
# riscv_ras

Parametrised return-address stack (RAS) for the RISC-V core's next-PC logic. It watches each retired or fetched control-transfer instruction, classifies it as call, return, call+return or none using the link-register convention (x1/x5), and predicts the target of returns from an internal circular stack. It sits beside the datapath's PC-source mux, generalising the fixed `jalr` handling to arbitrary XLEN and stack depth, with overflow, underflow and flush behaviour.

## Interface
- `XLEN`, 32, PC and address width.
- `DEPTH`, 8, stack entries; power of two, at least 2.
- `clk  in  1  clock; all state updates on the rising edge`
- `rst  in  1  asynchronous, active-high reset`
- `instr_valid  in  1  instr/pc are valid this cycle`
- `instr  in  32  instruction word (RV32 encoding regardless of XLEN)`
- `pc  in  XLEN  address of instr`
- `flush  in  1  synchronous clear of the stack (mispredict or trap)`
- `pred_valid  out  1  pred_target is a usable return prediction`
- `pred_target  out  XLEN  predicted return address`
- `count  out  $clog2(DEPTH)+1  live entries, 0..DEPTH`
- `lost  out  1  sticky: an entry was overwritten by overflow since the last reset or flush`

## Operation
- Link register: rd or rs1 ∈ {x1, x5}. Opcodes: JAL = 7'b1101111; JALR = 7'b1100111 with funct3 = 0. Any other instruction is NONE.
- Classification:
  - JAL with link rd: PUSH.
  - JAL with non-link rd: NONE.
  - JALR, link rd, non-link rs1: PUSH.
  - JALR, non-link rd, link rs1: POP.
  - JALR, both link, rs1 == rd: PUSH.
  - JALR, both link, rs1 != rd: POPPUSH.
  - JALR, neither link: NONE.
- The pushed value is always `pc + 4`, truncated modulo 2^XLEN.
- Prediction is combinational and only for POP or POPPUSH with `instr_valid`:
  - `pred_target = stack[tos]`.
  - `pred_valid = (count != 0)`.
  - In every other case `pred_valid = 0` and `pred_target = 0`.
- State is a circular buffer `stack[DEPTH]`, a top pointer `tos` (index of the newest entry) and `count`.
- PUSH:
  - `tos <= tos+1` (wraps modulo DEPTH), then write the entry.
  - If `count == DEPTH`, the oldest entry is overwritten, `count` stays at DEPTH and `lost <= 1`.
  - Otherwise `count` increments.
- POP:
  - If `count > 0`: `tos <= tos-1` (wraps) and `count` decrements. The vacated entry is not cleared.
  - If `count == 0` (underflow): no state change and `pred_valid = 0`.
- POPPUSH:
  - If `count > 0`: `stack[tos] <= pc+4`; `tos` and `count` are unchanged.
  - If `count == 0`: behaves as PUSH.
- `flush`: `tos <= 0`, `count <= 0`, `lost <= 0`. Entries are kept but are dead. `flush` has priority over a simultaneous `instr_valid` operation; that operation is discarded. The prediction output in the flush cycle still reflects the pre-flush state.
- `instr_valid = 0`: no state change.

## Timing
- Reset (asynchronous, takes effect immediately): all entries 0, `tos = 0`, `count = 0`, `lost = 0`, `pred_valid = 0`, `pred_target = 0`.
- Reset asserted mid-operation overrides everything. The first update after deassertion happens on the next rising edge.
- Prediction latency: 0 cycles (same cycle as `instr`). Update latency: 1 cycle, so an instruction in cycle N+1 sees the push/pop from cycle N.
- A pop in cycle N+1 immediately after a push in cycle N must return the value pushed in N; no bypass is needed because the update is registered.
- `count` and `lost` are registered outputs.

## Structure
- Header `riscv/ras.svh`: `ras_op_e` {RAS_NONE, RAS_PUSH, RAS_POP, RAS_POPPUSH}, opcode constants `OP_JAL` and `OP_JALR`, and the `is_link(reg)` macro/function.
- Sub-module `riscv_ras_decode`: purely combinational; instr → `ras_op_e`.
- `riscv_ras` holds the stack, pointer, counters and prediction mux.

## Test plan
- Reset, then pc = 0x100 with `0x008000ef` (jal ra, 8) → push 0x104, `count = 1`. Next cycle `0x00008067` (ret) → `pred_valid = 1`, `pred_target = 0x104`; afterwards `count = 0`.
- pc = 0x0 with `0x004180e7` (jalr ra, x3, 4) → push 0x4. Then pc = 0xC with `0x000080e7` (jalr ra, ra, 0) → push 0x10, `count = 2`. Two rets predict 0x10 then 0x4.
- DEPTH = 8: push 9 times with pcs 0x0, 0x10, …, 0x80 → `count = 8`, `lost = 1`. Eight rets predict 0x84 down to 0x14. A ninth ret gives `pred_valid = 0` and `count` stays 0.
- With 0x104 on the stack, pc = 0x200 with `0x000082e7` (jalr t0, ra, 0) → `pred_target = 0x104`, `count` stays 1, and the next ret predicts 0x204. Repeat on an empty stack → `pred_valid = 0`, `count = 1`.
- `flush` in the same cycle as a push with `count = 3` → next cycle `count = 0`, `lost = 0`, and a ret gives `pred_valid = 0`.
- XLEN = 16: pc = 0xFFFC with jal ra → pushed value 0x0000. Assert `rst` mid-cycle → outputs go to 0 immediately, without waiting for a clock edge.
